// File: rtl/window_accumulator.sv
// Sums WINDOW accepted adder results and holds each total on a registered valid/ready port.
// Optional build macro WINDOW_ACCUMULATOR_OVERLAP_EN keeps accumulating while a result is held.
module window_accumulator #(
  parameter  int DATA_WIDTH = 32,
  parameter  int WINDOW     = 8,
  localparam int ACC_WIDTH  = DATA_WIDTH + 1 + $clog2(WINDOW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   in_sum,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic                  out_partial
);

  localparam int              CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state_reg, state_next;
  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [ACC_WIDTH-1:0] out_acc_reg, out_acc_next;
  logic                 out_partial_reg, out_partial_next;
  logic                 live_reg;

  logic                 in_xfer;
  logic                 last;
  logic                 complete;
  logic                 close;
  logic [ACC_WIDTH-1:0] sample;
  logic [ACC_WIDTH-1:0] sum;

  assign last = (cnt_reg == LAST);

  // live_reg holds in_ready low until the first edge after reset release
`ifdef WINDOW_ACCUMULATOR_OVERLAP_EN
  assign in_ready = live_reg && !((state_reg == HOLD) && last);
`else
  assign in_ready = live_reg && (state_reg == ACCUM);
`endif

  assign out_valid   = (state_reg == HOLD);
  assign out_acc     = out_acc_reg;
  assign out_partial = out_partial_reg;

  always_comb begin
    in_xfer  = in_valid && in_ready;
    // Gate the sample so an undriven in_sum never reaches the accumulator
    sample   = in_xfer ? {{(ACC_WIDTH - DATA_WIDTH - 1){1'b0}}, in_sum} : '0;
    sum      = acc_reg + sample;
    complete = in_xfer && last;
    close    = complete || (flush && ((cnt_reg != '0) || in_xfer));

    state_next       = state_reg;
    acc_next         = acc_reg;
    cnt_next         = cnt_reg;
    out_acc_next     = out_acc_reg;
    out_partial_next = out_partial_reg;

    case (state_reg)
      ACCUM: begin
        if (close) begin
          out_acc_next     = sum;
          out_partial_next = !complete;
          acc_next         = '0;
          cnt_next         = '0;
          state_next       = HOLD;
        end else if (in_xfer) begin
          acc_next = sum;
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HOLD: begin
        // Only reachable with overlap enabled; in_ready blocks the final sample here
        if (in_xfer) begin
          acc_next = sum;
          cnt_next = cnt_reg + CNT_W'(1);
        end
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ACCUM;
      acc_reg         <= '0;
      cnt_reg         <= '0;
      out_acc_reg     <= '0;
      out_partial_reg <= 1'b0;
      live_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      acc_reg         <= acc_next;
      cnt_reg         <= cnt_next;
      out_acc_reg     <= out_acc_next;
      out_partial_reg <= out_partial_next;
      live_reg        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_window_accumulator.sv
// Bench for window_accumulator (DATA_WIDTH=8, WINDOW=4): directed scenarios plus a
// negedge reference model feeding a result scoreboard.
module tb_window_accumulator;

  localparam int DW  = 8;
  localparam int WIN = 4;
  localparam int AW  = 11;

  typedef struct packed {
    logic [AW-1:0] acc;
    logic          partial;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW:0]   in_sum;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic          out_partial;

  int   checks_total  = 0;
  int   checks_passed = 0;
  bit   model_en      = 0;
  int   m_acc         = 0;
  int   m_cnt         = 0;
  bit   m_hold        = 0;
  int   n_out         = 0;
  res_t sb_q[$];

  window_accumulator #(.DATA_WIDTH(DW), .WINDOW(WIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_partial(out_partial)
  );

  always #5 clk = ~clk;

  // Reference model: compares against its current state, then predicts the coming edge
  always @(negedge clk) begin
    bit   exp_rdy, xfer, oxfer, comp, fh;
    int   samp;
    res_t r;
    if (!model_en) begin
      m_acc = 0; m_cnt = 0; m_hold = 0; sb_q.delete();
    end else begin
`ifdef WINDOW_ACCUMULATOR_OVERLAP_EN
      exp_rdy = !(m_hold && m_cnt == WIN - 1);
`else
      exp_rdy = !m_hold;
`endif
      checks_total++;
      if (in_ready !== exp_rdy) $display("FAIL model_in_ready: got %b want %b", in_ready, exp_rdy);
      else checks_passed++;
      checks_total++;
      if (out_valid !== m_hold) $display("FAIL model_out_valid: got %b want %b", out_valid, m_hold);
      else checks_passed++;
      xfer  = (in_valid === 1'b1) && (in_ready === 1'b1);
      oxfer = (out_valid === 1'b1) && (out_ready === 1'b1);
      if (m_hold) begin
        checks_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL scoreboard_empty: got out_acc %0d want no result", out_acc);
        end else if (out_acc !== sb_q[0].acc || out_partial !== sb_q[0].partial) begin
          $display("FAIL scoreboard_result: got %0d/%b want %0d/%b",
                   out_acc, out_partial, sb_q[0].acc, sb_q[0].partial);
        end else begin
          checks_passed++;
        end
        if (oxfer && sb_q.size() != 0) begin
          r = sb_q.pop_front();
          n_out++;
          $display("out #%0d acc=%0d partial=%b", n_out, r.acc, r.partial);
        end
      end
      samp = xfer ? int'(in_sum) : 0;
      comp = xfer && (m_cnt == WIN - 1);
      fh   = (flush === 1'b1) && (m_cnt != 0 || xfer);
      if (m_hold && oxfer) m_hold = 0;
      else if (m_hold) m_hold = 1;
      if (!m_hold && !(oxfer) && 0) m_hold = 0;
      if ((sb_q.size() == 0 || !(out_valid === 1'b1)) && !out_valid_pending() && (comp || fh)) begin
        r.acc = AW'(m_acc + samp); r.partial = !comp;
        sb_q.push_back(r);
        m_acc = 0; m_cnt = 0; m_hold = 1;
      end else if (xfer) begin
        m_acc += samp; m_cnt++;
      end
    end
  end

  // A result may only be loaded while the output register is empty before this edge
  function automatic bit out_valid_pending();
    return out_valid === 1'b1;
  endfunction

  task automatic idle();
    in_valid = 1'b0; in_sum = 'x; flush = 1'b0;
  endtask

  task automatic send(input int v, input bit fl);
    bit taken;
    int n;
    in_valid = 1'b1; in_sum = (DW+1)'(v); flush = fl; n = 0;
    do begin
      taken = (in_ready === 1'b1);
      @(posedge clk); #1; n++;
    end while (!taken && n < 20);
    flush = 1'b0;
    if (!taken) begin
      checks_total++;
      $display("FAIL send_timeout: got no accept want accept of %0d", v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; out_ready = 1'b1; idle();
    #3;
    checks_total++;
    if ({out_valid, out_acc, out_partial, in_ready} !== '0)
      $display("FAIL reset_outputs: got v=%b acc=%0d p=%b rdy=%b want all 0", out_valid, out_acc, out_partial, in_ready);
    else checks_passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    checks_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", in_ready);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_release: got %b want 1", in_ready);
    else checks_passed++;
    model_en = 1;
  endtask

  task automatic test_window(input int a, input int b, input int c, input int d, input int exp, input string nm);
    send(a, 0); send(b, 0); send(c, 0); send(d, 0); idle();
    checks_total++;
    if (out_valid !== 1'b1 || out_acc !== AW'(exp) || out_partial !== 1'b0)
      $display("FAIL %s: got v=%b acc=%0d p=%b want v=1 acc=%0d p=0", nm, out_valid, out_acc, out_partial, exp);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL %s_one_cycle: got out_valid %b want 0", nm, out_valid);
    else checks_passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0); idle();
    for (int i = 0; i < 5; i++) begin
      checks_total++;
      if (out_valid !== 1'b1 || out_acc !== AW'(10))
        $display("FAIL bp_hold: got v=%b acc=%0d want v=1 acc=10", out_valid, out_acc);
      else checks_passed++;
      checks_total++;
`ifdef WINDOW_ACCUMULATOR_OVERLAP_EN
      if (in_ready !== 1'b1) $display("FAIL bp_ready: got %b want 1", in_ready);
`else
      if (in_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", in_ready);
`endif
      else checks_passed++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL bp_release: got out_valid %b want 0", out_valid);
    else checks_passed++;
  endtask

  task automatic test_flush();
    send(7, 0); send(9, 0);
    in_valid = 1'b0; in_sum = 'x; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks_total++;
    if (out_valid !== 1'b1 || out_acc !== AW'(16) || out_partial !== 1'b1)
      $display("FAIL flush_partial: got v=%b acc=%0d p=%b want v=1 acc=16 p=1", out_valid, out_acc, out_partial);
    else checks_passed++;
    repeat (2) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    repeat (2) begin
      checks_total++;
      if (out_valid !== 1'b0) $display("FAIL flush_empty: got out_valid %b want 0", out_valid);
      else checks_passed++;
      @(posedge clk); #1;
    end
    send(1, 0); send(2, 0); send(3, 0); send(4, 1); idle();
    checks_total++;
    if (out_valid !== 1'b1 || out_acc !== AW'(10) || out_partial !== 1'b0)
      $display("FAIL flush_full: got v=%b acc=%0d p=%b want v=1 acc=10 p=0", out_valid, out_acc, out_partial);
    else checks_passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send(5, 0); send(6, 0); idle();
    #2 model_en = 0; rst = 1'b0;
    #1;
    checks_total++;
    if ({out_valid, out_acc, out_partial, in_ready} !== '0)
      $display("FAIL reset_mid_window: got v=%b acc=%0d p=%b rdy=%b want all 0", out_valid, out_acc, out_partial, in_ready);
    else checks_passed++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 model_en = 1;
    test_window(1, 1, 1, 1, 4, "after_reset");
    out_ready = 1'b0;
    send(100, 0); send(100, 0); send(100, 0); send(100, 0); idle();
    #2 model_en = 0; rst = 1'b0;
    #1;
    checks_total++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_partial !== 1'b0)
      $display("FAIL reset_mid_hold: got v=%b acc=%0d p=%b want all 0", out_valid, out_acc, out_partial);
    else checks_passed++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 model_en = 1; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_no_output: got out_valid %b want 0", out_valid);
    else checks_passed++;
  endtask

  task automatic test_random();
    int cyc = 0;
    int start = n_out;
    while (n_out - start < 1000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sum    = in_valid ? (DW+1)'($urandom_range(0, 510)) : 'x;
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1; cyc++;
    end
    idle(); out_ready = 1'b1;
    checks_total++;
    if (n_out - start < 1000) $display("FAIL random_timeout: got %0d windows want 1000", n_out - start);
    else checks_passed++;
    repeat (4) @(posedge clk); #1;
    checks_total++;
    if (sb_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL random_drain: got %0d pending v=%b want 0 pending v=0", sb_q.size(), out_valid);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_window(10, 20, 30, 40, 100, "basic_sum");
    test_window(510, 510, 510, 510, 2040, "max_sum");
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
